// File: rtl/prim_diff_ping_pkg.sv
// Shared types and helpers for the differential-channel ping scheduler.
//   ping_state_e : scheduler FSM states (Idle, Wait, Ping)
//   MaxCh        : widest channel bank that rr_next can serve
//   rr_next()    : round-robin search for the next enabled channel after 'last'
package prim_diff_ping_pkg;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Wait = 2'd1,
        Ping = 2'd2
    } ping_state_e;

    localparam int unsigned MaxCh = 32;

    // Returns the first index set in 'en' strictly after 'last', wrapping modulo 'num'.
    // Returns 'last' when no channel in range is enabled.
    function automatic int unsigned rr_next(input logic [MaxCh-1:0] en,
                                            input int unsigned      last,
                                            input int unsigned      num);
        int unsigned res;
        int unsigned idx;
        logic        found;
        res   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxCh; k++) begin
            idx = (last + k) % num;
            if ((k <= num) && !found && en[idx[4:0]]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_diff_ping_rr.sv
// Round-robin next-channel picker for the ping scheduler.
//   i_en    : per-channel enable mask
//   i_last  : index of the previously pinged channel
//   o_idx   : next enabled channel strictly after i_last (wrapping)
//   o_valid : at least one channel enabled
// NumCh must not exceed prim_diff_ping_pkg::MaxCh.
module prim_diff_ping_rr
    import prim_diff_ping_pkg::*;
#(
    parameter int unsigned NumCh = 4,
    parameter int unsigned CurW  = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic [NumCh-1:0] i_en,
    input  logic [CurW-1:0]  i_last,
    output logic [CurW-1:0]  o_idx,
    output logic             o_valid
);

    logic [MaxCh-1:0] w_en_ext;

    always_comb begin
        w_en_ext              = '0;
        w_en_ext[NumCh-1:0]   = i_en;
    end

    assign o_idx   = CurW'(rr_next(w_en_ext, 32'(i_last), NumCh));
    assign o_valid = |i_en;

endmodule

// File: rtl/prim_diff_ping_sched.sv
// Periodic ping scheduler for a bank of differential-pair channels.
// Round-robins a one-hot ping request over enabled channels, checks that each ack
// returns within timeout_i cycles, and keeps sticky per-channel failure flags.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : scheduler enable
//   period_i      : idle cycles between pings (0 behaves as 1)
//   timeout_i     : max cycles from req to ack
//   ch_en_i       : per-channel enable
//   ping_ok_i     : decoded ack pulse per channel
//   sigint_i      : decoder signal-integrity flag per channel
//   fail_clr_i    : clear sticky fail per channel
//   ping_req_o    : one-hot ping request, held until ack/timeout/abort
//   ping_fail_o   : sticky failure flags
//   busy_o        : high while pinging
//   cur_ch_o      : index of current/last pinged channel
// Build option: define PRIM_DIFF_PING_SIGINT_EN to turn sigint_i into a failure source.
module prim_diff_ping_sched
    import prim_diff_ping_pkg::*;
#(
    parameter int unsigned  NumCh    = 4,
    parameter int unsigned  PeriodW  = 16,
    parameter int unsigned  TimeoutW = 8,
    localparam int unsigned CurW     = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [PeriodW-1:0]  period_i,
    input  logic [TimeoutW-1:0] timeout_i,
    input  logic [NumCh-1:0]    ch_en_i,
    input  logic [NumCh-1:0]    ping_ok_i,
    input  logic [NumCh-1:0]    sigint_i,
    input  logic [NumCh-1:0]    fail_clr_i,
    output logic [NumCh-1:0]    ping_req_o,
    output logic [NumCh-1:0]    ping_fail_o,
    output logic                busy_o,
    output logic [CurW-1:0]     cur_ch_o
);

    ping_state_e         r_state, w_state_next;
    logic [PeriodW-1:0]  r_period_cnt, w_period_next, w_period_load;
    logic [TimeoutW-1:0] r_to_cnt, w_to_next;
    logic [CurW-1:0]     r_cur, w_cur_next;
    // Separate RR anchor so the first ping after reset lands on the lowest enabled channel
    // while cur_ch_o still resets to 0.
    logic [CurW-1:0]     r_last, w_last_next;
    logic [NumCh-1:0]    r_req, w_req_next;
    logic [NumCh-1:0]    r_fail, w_fail_next;

    logic [CurW-1:0]     w_rr_idx;
    logic                w_rr_valid;
    logic [NumCh-1:0]    w_cur_oh, w_ack_mask, w_spurious, w_to_fail, w_sig_fail;
    logic                w_ack, w_cur_en, w_sig_abort;

    prim_diff_ping_rr #(
        .NumCh (NumCh),
        .CurW  (CurW)
    ) u_rr (
        .i_en    (ch_en_i),
        .i_last  (r_last),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    assign w_period_load = (period_i == '0) ? PeriodW'(1) : period_i;
    assign w_cur_oh      = NumCh'(1) << r_cur;
    // Only the channel being pinged may ack; every other ack pulse is spurious.
    assign w_ack_mask    = (r_state == Ping) ? w_cur_oh : '0;
    assign w_spurious    = ping_ok_i & ~w_ack_mask;
    assign w_ack         = |(ping_ok_i & w_ack_mask);
    assign w_cur_en      = |(ch_en_i & w_cur_oh);

`ifdef PRIM_DIFF_PING_SIGINT_EN
    assign w_sig_fail  = sigint_i & ch_en_i;
    assign w_sig_abort = (r_state == Ping) && |(w_sig_fail & w_cur_oh);
`else
    logic w_unused_sigint;
    assign w_unused_sigint = ^sigint_i;
    assign w_sig_fail      = '0;
    assign w_sig_abort     = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_period_next = r_period_cnt;
        w_to_next     = r_to_cnt;
        w_cur_next    = r_cur;
        w_last_next   = r_last;
        w_req_next    = r_req;
        w_to_fail     = '0;
        if (!en_i || !(|ch_en_i)) begin
            w_state_next = Idle;
            w_req_next   = '0;
        end else begin
            unique case (r_state)
                Idle: begin
                    w_state_next  = Wait;
                    w_period_next = w_period_load;
                end
                Wait: begin
                    if ((r_period_cnt <= PeriodW'(1)) && w_rr_valid) begin
                        w_state_next = Ping;
                        w_cur_next   = w_rr_idx;
                        w_last_next  = w_rr_idx;
                        w_to_next    = '0;
                        w_req_next   = NumCh'(1) << w_rr_idx;
                    end else begin
                        w_period_next = r_period_cnt - PeriodW'(1);
                    end
                end
                Ping: begin
                    // Ack is checked before timeout so a same-cycle ack wins.
                    if (!w_cur_en || w_ack || w_sig_abort) begin
                        w_state_next  = Wait;
                        w_period_next = w_period_load;
                        w_req_next    = '0;
                    end else if (r_to_cnt == timeout_i) begin
                        w_to_fail     = w_cur_oh;
                        w_state_next  = Wait;
                        w_period_next = w_period_load;
                        w_req_next    = '0;
                    end else if (r_to_cnt != '1) begin
                        w_to_next = r_to_cnt + TimeoutW'(1);
                    end
                end
                default: begin
                    w_state_next = Idle;
                    w_req_next   = '0;
                end
            endcase
        end
        // Set beats clear.
        w_fail_next = (r_fail & ~fail_clr_i) | w_spurious | w_sig_fail | w_to_fail;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= Idle;
            r_period_cnt <= '0;
            r_to_cnt     <= '0;
            r_cur        <= '0;
            r_last       <= CurW'(NumCh - 1);
            r_req        <= '0;
            r_fail       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_period_cnt <= w_period_next;
            r_to_cnt     <= w_to_next;
            r_cur        <= w_cur_next;
            r_last       <= w_last_next;
            r_req        <= w_req_next;
            r_fail       <= w_fail_next;
        end
    end

    assign ping_req_o  = r_req;
    assign ping_fail_o = r_fail;
    assign busy_o      = (r_state == Ping);
    assign cur_ch_o    = r_cur;

endmodule

// File: tb/tb_prim_diff_ping_sched.sv
// Self-checking bench for prim_diff_ping_sched (NumCh=4, default widths).
module tb_prim_diff_ping_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [15:0] period_i;
    logic [7:0]  timeout_i;
    logic [3:0]  ch_en_i, ping_ok_i, sigint_i, fail_clr_i;
    logic [3:0]  ping_req_o, ping_fail_o;
    logic        busy_o;
    logic [1:0]  cur_ch_o;

    prim_diff_ping_sched dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .period_i    (period_i),
        .timeout_i   (timeout_i),
        .ch_en_i     (ch_en_i),
        .ping_ok_i   (ping_ok_i),
        .sigint_i    (sigint_i),
        .fail_clr_i  (fail_clr_i),
        .ping_req_o  (ping_req_o),
        .ping_fail_o (ping_fail_o),
        .busy_o      (busy_o),
        .cur_ch_o    (cur_ch_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: activity (0 none, 1 counting down, 2 ping outstanding).
    int         m_mode, m_wait, m_age, m_cur, m_last;
    logic [3:0] m_fail;
    int         ack_delay;

    int         rises, gap, hi_len, idx;
    logic [3:0] prev, bad, exp_fail, exp_req;
    int         exp1[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r;
        int n;
        r = 99;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                r = i;
                n++;
            end
        end
        if (n != 1) r = 99;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_wait = 0;
        m_age  = 0;
        m_cur  = 0;
        m_last = 3;
        m_fail = 4'b0000;
    endtask

    task automatic model_step();
        logic [3:0] set;
        int         per;
        logic       sig_abort;
        int         nxt;
        set       = 4'b0000;
        sig_abort = 1'b0;
        nxt       = m_last;
        for (int j = 0; j < 4; j++) begin
            if (ping_ok_i[j] && !(m_mode == 2 && j == m_cur)) set[j] = 1'b1;
        end
`ifdef PRIM_DIFF_PING_SIGINT_EN
        set = set | (sigint_i & ch_en_i);
        sig_abort = sigint_i[m_cur];
`endif
        per = (period_i == 16'd0) ? 1 : int'(period_i);
        if (!en_i || ch_en_i == 4'b0000) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_wait = per;
        end else if (m_mode == 1) begin
            if (m_wait <= 1) begin
                for (int k = 1; k <= 4; k++) begin
                    if (ch_en_i[(m_last + k) % 4]) begin
                        nxt = (m_last + k) % 4;
                        break;
                    end
                end
                m_cur  = nxt;
                m_last = nxt;
                m_mode = 2;
                m_age  = 0;
            end else begin
                m_wait--;
            end
        end else begin
            if (!ch_en_i[m_cur] || ping_ok_i[m_cur] || (sig_abort && m_mode == 2)) begin
                m_mode = 1;
                m_wait = per;
            end else if (m_age == int'(timeout_i)) begin
                set[m_cur] = 1'b1;
                m_mode     = 1;
                m_wait     = per;
            end else if (m_age < 255) begin
                m_age++;
            end
        end
        m_fail = (m_fail & ~fail_clr_i) | set;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_req"}, ping_req_o, (m_mode == 2) ? (4'b0001 << m_cur) : 4'b0000);
        chk({tag, "_fail"}, ping_fail_o, m_fail);
        chk({tag, "_busy"}, busy_o, (m_mode == 2));
        chk({tag, "_cur"}, cur_ch_o, m_cur);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk_i);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive_ack();
        ping_ok_i = 4'b0000;
        if (m_mode == 2 && ack_delay >= 0 && m_age == ack_delay) ping_ok_i[m_cur] = 1'b1;
    endtask

    // Asserts reset away from the clock edge; outputs must clear without a clock.
    task automatic do_reset();
        rst_ni     = 1'b0;
        en_i       = 1'b0;
        period_i   = 16'd0;
        timeout_i  = 8'd0;
        ch_en_i    = 4'b0000;
        ping_ok_i  = 4'b0000;
        sigint_i   = 4'b0000;
        fail_clr_i = 4'b0000;
        ack_delay  = -1;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        do_reset();

        // Round-robin across all channels with prompt acks.
        en_i = 1'b1; ch_en_i = 4'b1111; period_i = 16'd3; timeout_i = 8'd5; ack_delay = 2;
        rises = 0; gap = 0; prev = 4'b0000;
        for (int c = 0; c < 80 && rises < 5; c++) begin
            drive_ack();
            cycle("t1");
            if (ping_req_o != 4'b0000 && prev == 4'b0000) begin
                chk("t1_ch", oh2idx(ping_req_o), exp1[rises]);
                if (rises > 0) chk("t1_gap", gap, 3);
                rises++;
            end
            if (ping_req_o == 4'b0000) gap++;
            else gap = 0;
            prev = ping_req_o;
        end
        chk("t1_rises", rises, 5);
        chk("t1_nofail", ping_fail_o, 4'b0000);

        // Only channels 1 and 3 enabled.
        do_reset();
        en_i = 1'b1; ch_en_i = 4'b1010; period_i = 16'd2; timeout_i = 8'd5; ack_delay = 1;
        rises = 0; prev = 4'b0000; bad = 4'b0000;
        for (int c = 0; c < 80 && rises < 4; c++) begin
            drive_ack();
            cycle("t2");
            bad = bad | (ping_req_o & 4'b0101);
            if (ping_req_o != 4'b0000 && prev == 4'b0000) begin
                chk("t2_ch", oh2idx(ping_req_o), (rises % 2 == 0) ? 1 : 3);
                rises++;
            end
            prev = ping_req_o;
        end
        chk("t2_rises", rises, 4);
        chk("t2_never02", bad, 4'b0000);

        // Ack withheld on ch2: timeout after six held cycles, then clear.
        do_reset();
        en_i = 1'b1; ch_en_i = 4'b0100; period_i = 16'd3; timeout_i = 8'd5; ack_delay = -1;
        for (int c = 0; c < 20 && ping_req_o == 4'b0000; c++) cycle("t3w");
        hi_len = 0;
        for (int c = 0; c < 20 && ping_req_o != 4'b0000; c++) begin
            hi_len++;
            cycle("t3h");
        end
        chk("t3_hold", hi_len, 6);
        chk("t3_fail", ping_fail_o, 4'b0100);
        fail_clr_i = 4'b0100;
        cycle("t3c");
        fail_clr_i = 4'b0000;
        chk("t3_clr", ping_fail_o, 4'b0000);

        // Spurious ack on ch1 while ch0 is pinged; ch0 still acked normally.
        do_reset();
        en_i = 1'b1; ch_en_i = 4'b1111; period_i = 16'd2; timeout_i = 8'd5; ack_delay = -1;
        for (int c = 0; c < 20 && ping_req_o == 4'b0000; c++) cycle("t4w");
        chk("t4_first", ping_req_o, 4'b0001);
        ping_ok_i = 4'b0010;
        cycle("t4s");
        ping_ok_i = 4'b0000;
        cycle("t4a");
        ping_ok_i = 4'b0001;
        cycle("t4k");
        ping_ok_i = 4'b0000;
        chk("t4_fail", ping_fail_o, 4'b0010);
        chk("t4_drop", ping_req_o, 4'b0000);

        // Ack exactly at timeout: ack wins. Then en_i dropped mid-ping.
        do_reset();
        en_i = 1'b1; ch_en_i = 4'b0001; period_i = 16'd1; timeout_i = 8'd3; ack_delay = 3;
        for (int c = 0; c < 20 && ping_req_o == 4'b0000; c++) begin
            drive_ack();
            cycle("t5w");
        end
        hi_len = 0;
        for (int c = 0; c < 20 && ping_req_o != 4'b0000; c++) begin
            hi_len++;
            drive_ack();
            cycle("t5h");
        end
        chk("t5_hold", hi_len, 4);
        chk("t5_nofail", ping_fail_o, 4'b0000);
        ack_delay = -1;
        ping_ok_i = 4'b0000;
        for (int c = 0; c < 20 && ping_req_o == 4'b0000; c++) cycle("t5w2");
        cycle("t5p");
        en_i = 1'b0;
        cycle("t5d");
        chk("t5_req_off", ping_req_o, 4'b0000);
        chk("t5_busy_off", busy_o, 1'b0);
        cycle("t5i");
        en_i = 1'b1;
        for (int c = 0; c < 6; c++) cycle("t5r");

        // Reset while pinging with a sticky flag set.
        ping_ok_i = 4'b1000;
        cycle("mr_s");
        ping_ok_i = 4'b0000;
        for (int c = 0; c < 20 && ping_req_o == 4'b0000; c++) cycle("mr_w");
        chk("mr_pre_busy", busy_o, 1'b1);
        do_reset();
        chk("mr_fail", ping_fail_o, 4'b0000);

        // Signal-integrity flag on the pinged channel.
        en_i = 1'b1; ch_en_i = 4'b1111; period_i = 16'd2; timeout_i = 8'd6; ack_delay = -1;
        for (int c = 0; c < 20 && ping_req_o == 4'b0000; c++) cycle("t6w");
        idx = oh2idx(ping_req_o);
        sigint_i = ping_req_o;
`ifdef PRIM_DIFF_PING_SIGINT_EN
        exp_fail = ping_req_o;
        exp_req  = 4'b0000;
`else
        exp_fail = 4'b0000;
        exp_req  = ping_req_o;
`endif
        cycle("t6s");
        sigint_i = 4'b0000;
        chk("t6_fail", ping_fail_o, exp_fail);
        chk("t6_req", ping_req_o, exp_req);

        // Randomized traffic against the model.
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            period_i  = 16'($urandom_range(0, 4));
            timeout_i = 8'($urandom_range(0, 6));
            ch_en_i   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            ack_delay = int'($urandom_range(0, 8)) - 1;
            for (int c = 0; c < 50; c++) begin
                en_i = ($urandom_range(0, 29) != 0);
                drive_ack();
                if ($urandom_range(0, 24) == 0) ping_ok_i = ping_ok_i | 4'($urandom_range(1, 15));
                fail_clr_i = ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'b0000;
                sigint_i   = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
                cycle("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
